// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, error codes, FSM states and instruction field offsets shared by dispatch and ALU
package alu_pkg;
  localparam logic [3:0] OPC_ADD  = 4'h0;
  localparam logic [3:0] OPC_SUB  = 4'h1;
  localparam logic [3:0] OPC_MULT = 4'h2;
  localparam logic [3:0] OPC_AND  = 4'h3;
  localparam logic [3:0] OPC_DIV  = 4'h4;
  localparam logic [3:0] OPC_MOD  = 4'h5;
  localparam logic [3:0] OPC_LT   = 4'h6;
  localparam logic [3:0] OPC_LE   = 4'h7;
  localparam logic [3:0] OPC_NOP  = 4'h8;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_ERR} state_t;
endpackage

// File: rtl/alu_dispatch_if.sv
// alu_dispatch_if: instruction, load, ALU and result/error signals of the dispatcher
interface alu_dispatch_if #(parameter int DATA_W = 16, parameter int AW = 3, parameter int OPC_W = 4);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [OPC_W-1:0]  alu_operator;
  logic [DATA_W-1:0] alu_op1;
  logic [DATA_W-1:0] alu_op2;
  logic [DATA_W-1:0] alu_out;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [AW-1:0]     res_rd;
  logic              err_valid;
  logic [1:0]        err_code;
  logic              busy;
  logic [15:0]       op_count;
  modport slave (
    input  in_valid, in_instr, wr_en, wr_addr, wr_data, alu_out,
    output in_ready, wr_ready, alu_operator, alu_op1, alu_op2,
           res_valid, res_data, res_rd, err_valid, err_code, busy, op_count
  );
  modport master (
    output in_valid, in_instr, wr_en, wr_addr, wr_data, alu_out,
    input  in_ready, wr_ready, alu_operator, alu_op1, alu_op2,
           res_valid, res_data, res_rd, err_valid, err_code, busy, op_count
  );
endinterface

// File: rtl/alu16.sv
// alu16: combinational 16-bit ALU sharing the dispatcher opcode set
module alu16 import alu_pkg::*; #(parameter int W = 16) (
  input  logic [3:0]   operator,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  always_comb begin
    y = '0;
    case (operator)
      OPC_ADD:  y = a + b;
      OPC_SUB:  y = a - b;
      OPC_MULT: y = a * b;
      OPC_AND:  y = a & b;
      OPC_DIV:  y = (b == '0) ? '0 : a / b;
      OPC_MOD:  y = (b == '0) ? '0 : a % b;
      OPC_LT:   y = W'(a < b);
      OPC_LE:   y = W'(a <= b);
      default:  y = '0;
    endcase
  end
endmodule

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x DATA_W register file, one write port, two async read ports, async clear
module alu_regfile #(parameter int DATA_W = 16, parameter int NREG = 8, parameter int AW = 3) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [DATA_W-1:0] mem [NREG];
  always_ff @(posedge clk or posedge rst)
    if (rst) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch: accepts ALU instructions, fetches operands, drives the ALU and writes results back
module alu_dispatch import alu_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = 3,
  parameter int OPC_W  = 4
) (
  input logic clk,
  input logic rst,
  alu_dispatch_if.slave bus
);
  state_t state, nxt;
  logic [3:0] opc, in_opc;
  logic [AW-1:0] rd, res_rd_q;
  logic [DATA_W-1:0] op1_q, op2_q, rd1, rd2, res_q;
  logic [1:0] ecode, ecode_nxt;
  logic [15:0] cnt;
  logic accept, exec, wb, div0;
  assign in_opc = bus.in_instr[OPC_LSB +: 4];
  assign accept = bus.in_valid && state == S_IDLE;
  assign exec = state == S_EXEC;
  assign wb = state == S_WB;
  assign div0 = (opc == OPC_DIV || opc == OPC_MOD) && op2_q == '0;
  assign ecode_nxt = (state == S_IDLE) ? ERR_ILLEGAL : ERR_DIV0;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = accept ? (in_opc[3] ? S_ERR : S_EXEC) : S_IDLE;
      S_EXEC:  nxt = div0 ? S_ERR : S_WB;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= S_IDLE;
      opc      <= '0;
      rd       <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      res_q    <= '0;
      res_rd_q <= '0;
      ecode    <= ERR_NONE;
      cnt      <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        opc   <= in_opc;
        rd    <= bus.in_instr[RD_LSB +: AW];
        op1_q <= rd1;
        op2_q <= rd2;
      end
      // a zero-divisor result is dropped here so res_data keeps its previous value
      if (exec && nxt == S_WB) begin
        res_q    <= bus.alu_out;
        res_rd_q <= rd;
      end
      if (nxt == S_ERR) ecode <= ecode_nxt;
      if (wb) cnt <= cnt + 16'd1;
    end
  alu_regfile #(.DATA_W(DATA_W), .NREG(NREG), .AW(AW)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (wb || (bus.wr_en && bus.wr_ready)),
    .waddr (wb ? res_rd_q : bus.wr_addr),
    .wdata (wb ? res_q : bus.wr_data),
    .ra1   (bus.in_instr[RS1_LSB +: AW]),
    .ra2   (bus.in_instr[RS2_LSB +: AW]),
    .rd1   (rd1),
    .rd2   (rd2)
  );
  assign bus.in_ready     = state == S_IDLE;
  assign bus.busy         = state != S_IDLE;
  assign bus.wr_ready     = !wb;
  assign bus.alu_operator = exec ? OPC_W'(opc) : OPC_W'(OPC_NOP);
  assign bus.alu_op1      = exec ? op1_q : '0;
  assign bus.alu_op2      = exec ? op2_q : '0;
  assign bus.res_valid    = wb;
  assign bus.res_data     = res_q;
  assign bus.res_rd       = res_rd_q;
  assign bus.err_valid    = state == S_ERR;
  assign bus.err_code     = ecode;
  assign bus.op_count     = cnt;
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: directed checks of alu_dispatch driving an alu16
module tb_alu_dispatch;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  alu_dispatch_if bus();
  alu_dispatch dut (.clk(clk), .rst(rst), .bus(bus));
  alu16 alu (.operator(bus.alu_operator), .a(bus.alu_op1), .b(bus.alu_op2), .y(bus.alu_out));

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    bus.wr_en = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ins, output logic rv, output logic [15:0] rdat,
                       output logic [2:0] rrd, output logic ev, output logic [1:0] ec,
                       output int lat, output logic used);
    int n;
    rv = 0; ev = 0; rdat = 0; rrd = 0; ec = 0; lat = 0; used = 0;
    bus.in_instr = ins;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 10) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 5 && !rv && !ev; i++) begin
      if (bus.alu_operator != OPC_NOP) used = 1;
      if (bus.res_valid) begin rv = 1; rdat = bus.res_data; rrd = bus.res_rd; lat = i; end
      if (bus.err_valid) begin ev = 1; ec = bus.err_code; lat = i; end
      if (!rv && !ev) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 0; bus.in_instr = 0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    vecs++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errs++; $display("FAIL reset_idle: ready=%b busy=%b want 1 0", bus.in_ready, bus.busy); end
    vecs++; if (bus.alu_operator !== 4'h8 || bus.alu_op1 !== 0 || bus.alu_op2 !== 0) begin errs++; $display("FAIL reset_alu: opr=%h op1=%h op2=%h want 8 0 0", bus.alu_operator, bus.alu_op1, bus.alu_op2); end
    vecs++; if (bus.res_valid !== 0 || bus.res_data !== 0 || bus.res_rd !== 0 || bus.err_valid !== 0 || bus.err_code !== 0) begin errs++; $display("FAIL reset_res: rv=%b rd=%h rr=%h ev=%b ec=%b want zeros", bus.res_valid, bus.res_data, bus.res_rd, bus.err_valid, bus.err_code); end
    vecs++; if (bus.op_count !== 0 || bus.wr_ready !== 1) begin errs++; $display("FAIL reset_cnt: cnt=%h wr_ready=%b want 0 1", bus.op_count, bus.wr_ready); end
  endtask

  task automatic test_add_sub;
    logic rv, ev, used; logic [15:0] rdat; logic [2:0] rrd; logic [1:0] ec; int lat;
    load(3'd1, 16'd7);
    load(3'd2, 16'd5);
    issue(16'h0650, rv, rdat, rrd, ev, ec, lat, used);
    vecs++; if (rv !== 1 || ev !== 0 || lat != 2) begin errs++; $display("FAIL add_pulse: rv=%b ev=%b lat=%0d want 1 0 2", rv, ev, lat); end
    vecs++; if (rdat !== 16'd12 || rrd !== 3'd3) begin errs++; $display("FAIL add_res: data=%h rd=%0d want 000c 3", rdat, rrd); end
    vecs++; if (used !== 1 || bus.op_count !== 16'd1) begin errs++; $display("FAIL add_cnt: used=%b cnt=%0d want 1 1", used, bus.op_count); end
    issue(16'h18C8, rv, rdat, rrd, ev, ec, lat, used);
    vecs++; if (rv !== 1 || rdat !== 16'd5 || rrd !== 3'd4 || bus.op_count !== 16'd2) begin errs++; $display("FAIL sub_res: rv=%b data=%h rd=%0d cnt=%0d want 1 0005 4 2", rv, rdat, rrd, bus.op_count); end
  endtask

  task automatic test_div0;
    logic rv, ev, used; logic [15:0] rdat; logic [2:0] rrd; logic [1:0] ec; int lat;
    load(3'd2, 16'd0);
    load(3'd5, 16'h0055);
    issue(16'h4A50, rv, rdat, rrd, ev, ec, lat, used);
    vecs++; if (ev !== 1 || ec !== 2'b01 || rv !== 0 || lat != 2) begin errs++; $display("FAIL div0_err: ev=%b ec=%b rv=%b lat=%0d want 1 01 0 2", ev, ec, rv, lat); end
    vecs++; if (dut.u_rf.mem[5] !== 16'h0055 || bus.op_count !== 16'd2 || bus.res_data !== 16'd5) begin errs++; $display("FAIL div0_state: r5=%h cnt=%0d res=%h want 0055 2 0005", dut.u_rf.mem[5], bus.op_count, bus.res_data); end
    issue(16'h5A50, rv, rdat, rrd, ev, ec, lat, used);
    vecs++; if (ev !== 1 || ec !== 2'b01 || rv !== 0) begin errs++; $display("FAIL mod0_err: ev=%b ec=%b rv=%b want 1 01 0", ev, ec, rv); end
  endtask

  task automatic test_illegal;
    logic rv, ev, used; logic [15:0] rdat; logic [2:0] rrd; logic [1:0] ec; int lat;
    issue(16'h9000, rv, rdat, rrd, ev, ec, lat, used);
    vecs++; if (ev !== 1 || ec !== 2'b10 || lat != 1 || rv !== 0) begin errs++; $display("FAIL illegal_err: ev=%b ec=%b lat=%0d rv=%b want 1 10 1 0", ev, ec, lat, rv); end
    vecs++; if (used !== 0 || bus.op_count !== 16'd2) begin errs++; $display("FAIL illegal_nop: used=%b cnt=%0d want 0 2", used, bus.op_count); end
    vecs++; if (bus.err_code !== 2'b10 || bus.err_valid !== 0) begin errs++; $display("FAIL illegal_hold: ec=%b ev=%b want 10 0", bus.err_code, bus.err_valid); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] prog [3];
    logic [15:0] rdat [3];
    logic [2:0] rrd [3];
    int acc [3];
    int nacc, nres, wcyc;
    logic rdy;
    prog = '{16'h0A50, 16'h2C50, 16'h1888};
    nacc = 0; nres = 0; wcyc = -10;
    load(3'd1, 16'd3);
    load(3'd2, 16'd4);
    bus.in_instr = prog[0];
    bus.in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (bus.res_valid && nres == 0) begin
        vecs++; if (bus.wr_ready !== 0) begin errs++; $display("FAIL wb_stall: wr_ready=%b want 0", bus.wr_ready); end
        bus.wr_en = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = 16'hABCD;
        wcyc = c;
      end
      if (c == wcyc + 1) begin
        vecs++; if (dut.u_rf.mem[7] !== 16'h0000) begin errs++; $display("FAIL wb_noload: r7=%h want 0000", dut.u_rf.mem[7]); end
      end
      if (c == wcyc + 2) begin
        vecs++; if (dut.u_rf.mem[7] !== 16'hABCD) begin errs++; $display("FAIL wb_lateload: r7=%h want abcd", dut.u_rf.mem[7]); end
        bus.wr_en = 1'b0;
      end
      if (rdy && nacc < 3) begin
        acc[nacc] = c;
        nacc++;
        if (nacc < 3) bus.in_instr = prog[nacc];
        else bus.in_valid = 1'b0;
      end
      if (bus.res_valid && nres < 3) begin rdat[nres] = bus.res_data; rrd[nres] = bus.res_rd; nres++; end
    end
    vecs++; if (nacc != 3 || nres != 3) begin errs++; $display("FAIL b2b_count: acc=%0d res=%0d want 3 3", nacc, nres); end
    else begin
      vecs++; if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin errs++; $display("FAIL b2b_spacing: %0d %0d %0d want step 3", acc[0], acc[1], acc[2]); end
      vecs++; if (rdat[0] !== 16'd7 || rrd[0] !== 3'd5) begin errs++; $display("FAIL b2b_r0: %h/%0d want 0007/5", rdat[0], rrd[0]); end
      vecs++; if (rdat[1] !== 16'd12 || rrd[1] !== 3'd6) begin errs++; $display("FAIL b2b_r1: %h/%0d want 000c/6", rdat[1], rrd[1]); end
      vecs++; if (rdat[2] !== 16'd1 || rrd[2] !== 3'd4) begin errs++; $display("FAIL b2b_r2: %h/%0d want 0001/4", rdat[2], rrd[2]); end
    end
    vecs++; if (bus.op_count !== 16'd5) begin errs++; $display("FAIL b2b_cnt: cnt=%0d want 5", bus.op_count); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    bus.in_instr = 16'h2C50;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    vecs++; if (bus.alu_operator !== OPC_MULT || bus.alu_op1 !== 16'd3) begin errs++; $display("FAIL mid_exec: opr=%h op1=%h want 2 0003", bus.alu_operator, bus.alu_op1); end
    rst = 1'b1;
    #1;
    vecs++; if (bus.busy !== 0 || bus.res_valid !== 0 || bus.op_count !== 0 || bus.res_data !== 0 || bus.err_code !== 0) begin errs++; $display("FAIL mid_outs: busy=%b rv=%b cnt=%h res=%h ec=%b want zeros", bus.busy, bus.res_valid, bus.op_count, bus.res_data, bus.err_code); end
    vecs++; if (bus.alu_operator !== 4'h8 || dut.u_rf.mem[1] !== 0 || dut.u_rf.mem[7] !== 0) begin errs++; $display("FAIL mid_regs: opr=%h r1=%h r7=%h want 8 0 0", bus.alu_operator, dut.u_rf.mem[1], dut.u_rf.mem[7]); end
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (bus.res_valid || bus.err_valid) seen = 1; end
    vecs++; if (seen !== 0 || dut.u_rf.mem[6] !== 0 || bus.op_count !== 0) begin errs++; $display("FAIL mid_after: pulse=%b r6=%h cnt=%0d want 0 0 0", seen, dut.u_rf.mem[6], bus.op_count); end
  endtask

  task automatic test_boundary;
    logic rv, ev, used; logic [15:0] rdat; logic [2:0] rrd; logic [1:0] ec; int lat;
    load(3'd1, 16'hFFFF);
    load(3'd2, 16'd1);
    issue(16'h0650, rv, rdat, rrd, ev, ec, lat, used);
    vecs++; if (rv !== 1 || rdat !== 16'h0000 || rrd !== 3'd3) begin errs++; $display("FAIL add_wrap: rv=%b data=%h rd=%0d want 1 0000 3", rv, rdat, rrd); end
    issue(16'h6088, rv, rdat, rrd, ev, ec, lat, used);
    vecs++; if (rv !== 1 || rdat !== 16'd1 || rrd !== 3'd0) begin errs++; $display("FAIL lt: rv=%b data=%h rd=%0d want 1 0001 0", rv, rdat, rrd); end
    vecs++; if (bus.op_count !== 16'd2) begin errs++; $display("FAIL cnt_pre: cnt=%0d want 2", bus.op_count); end
    force dut.cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.cnt;
    issue(16'h7848, rv, rdat, rrd, ev, ec, lat, used);
    vecs++; if (rv !== 1 || rdat !== 16'd1 || rrd !== 3'd4) begin errs++; $display("FAIL le: rv=%b data=%h rd=%0d want 1 0001 4", rv, rdat, rrd); end
    vecs++; if (bus.op_count !== 16'h0000) begin errs++; $display("FAIL cnt_wrap: cnt=%h want 0000", bus.op_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_add_sub;
    test_div0;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    test_boundary;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
